color_fill_sequencer: RTL

- Walks the full 32×24 cell grid once per request.
- For each cell it presents `x_index`/`y_index` to `color_generator` and registers the returned 8-bit `color`.
- It then writes that color into the frame buffer through a valid/ready write port.
- It sits between the top-level frame control (start/abort) and the frame-buffer write arbiter.

---
 rtl/life_game_pkg.sv | 18 +
 rtl/cell_index_counter.sv | 36 +++
 rtl/color_fill_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/life_game_pkg.sv
// Shared grid constants and the frame-fill FSM state type.
package life_game_pkg;

    localparam int GRID_COLS = 32;
    localparam int GRID_ROWS = 24;
    localparam int X_W       = 5;
    localparam int Y_W       = 5;
    localparam int COLOR_W   = 8;
    localparam int ADDR_W    = X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WRITE,
        DONE
    } fill_state_t;

endpackage

// File: rtl/cell_index_counter.sv
// Raster-order x/y cell counter with column wrap and a last-cell flag.
module cell_index_counter #(
    parameter int COLS = 32,
    parameter int ROWS = 24,
    parameter int X_W  = 5,
    parameter int Y_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_fill_sequencer.sv
// Walks the cell grid once per start, fetching each cell's color and writing it to the frame buffer.
module color_fill_sequencer
    import life_game_pkg::*;
#(
    parameter int GRID_COLS = life_game_pkg::GRID_COLS,
    parameter int GRID_ROWS = life_game_pkg::GRID_ROWS,
    parameter int X_W       = life_game_pkg::X_W,
    parameter int Y_W       = life_game_pkg::Y_W,
    parameter int COLOR_W   = life_game_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [X_W-1:0]     x_index,
    output logic [Y_W-1:0]     y_index,
    input  logic [COLOR_W-1:0] color,
    output logic               wr_en,
    output logic [X_W+Y_W-1:0] wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    input  logic               wr_ready,
    output logic               busy,
    output logic               done
);

    fill_state_t state, state_next;
    logic        idx_clear;
    logic        idx_advance;
    logic        idx_last;
    logic        load;

    cell_index_counter #(
        .COLS (GRID_COLS),
        .ROWS (GRID_ROWS),
        .X_W  (X_W),
        .Y_W  (Y_W)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (idx_clear),
        .advance (idx_advance),
        .x       (x_index),
        .y       (y_index),
        .last    (idx_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_clear   = 1'b0;
        idx_advance = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                load       = 1'b1;
                state_next = WRITE;
            end
            WRITE: begin
                if (wr_ready) begin
                    if (idx_last) begin
                        state_next = DONE;
                    end else begin
                        idx_advance = 1'b1;
                        state_next  = ISSUE;
                    end
                end
            end
            DONE: begin
                idx_clear  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over everything the current state wanted to do.
        if (abort && state != IDLE) begin
            state_next  = IDLE;
            idx_clear   = 1'b1;
            idx_advance = 1'b0;
            load        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (load) begin
            wr_addr <= {y_index, x_index};
            wr_data <= color;
        end
    end

    assign wr_en = (state == WRITE);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

endmodule
